regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port issue_valid  input  1: an instruction that writes issue_rd is being issued.
REQ-006 SHALL have port issue_rd  input  ADDR_WIDTH: destination register of the issued instruction.
REQ-007 SHALL have port issue_ready  output  1: issue is accepted this cycle.
REQ-008 SHALL have port exu_valid, exu_rd, exu_data  input  1/ADDR_WIDTH/DATA_WIDTH: EXU writeback request.
REQ-009 SHALL have port exu_ready  output  1: EXU request is granted this cycle.
REQ-010 SHALL have port lsu_valid, lsu_rd, lsu_data  input  1/ADDR_WIDTH/DATA_WIDTH: LSU writeback request.
REQ-011 SHALL have port lsu_ready  output  1: LSU request is granted this cycle.
REQ-012 SHALL have port rf_we, rf_wa, rf_wd  output  1/ADDR_WIDTH/DATA_WIDTH: drives the register-file write port.
REQ-013 SHALL have port ra1, ra2  input  ADDR_WIDTH: decode-stage read addresses.
REQ-014 SHALL have port hz1, hz2  output  1: read-after-write hazard flag for ra1 and ra2.
REQ-015 SHALL have port pending  output  2**ADDR_WIDTH: scoreboard of registers awaiting writeback.

Function
REQ-016 SHALL accept a handshake only when valid and ready are both high in the same cycle.
REQ-017 SHALL grant at most one of exu_ready and lsu_ready per cycle; each ready is combinational from the valids and the last_grant flop.
REQ-018 SHALL grant the sole valid requester when only one requester is valid.
REQ-019 SHALL, when both requesters are valid, grant the requester not granted most recently (round-robin); last_grant updates only on an accepted handshake.
REQ-020 SHALL keep a requester's rd and data stable while it is valid and not ready; the arbiter relies on this and does not buffer them.
REQ-021 SHALL register the write port with fixed 1-cycle latency: accept in cycle N gives rf_we=1, rf_wa=rd, rf_wd=data in cycle N+1.
REQ-022 SHALL drive rf_we=0 in any cycle following a cycle with no accepted handshake; rf_wa and rf_wd then hold their previous values.
REQ-023 SHALL accept a writeback to rd=0 normally but SHALL NOT assert rf_we for it.
REQ-024 SHALL drive issue_ready = !pending[issue_rd] (stall on WAW); issue_ready=1 whenever issue_rd=0.
REQ-025 SHALL set pending[issue_rd] on the edge ending a cycle with issue_valid & issue_ready and issue_rd!=0.
REQ-026 SHALL clear pending[rd] on the edge ending a cycle in which a writeback to rd is accepted.
REQ-027 SHALL let set win when set and clear hit the same rd in the same cycle (new producer).
REQ-028 SHALL hold pending[0]=0 at all times.
REQ-029 SHALL drive hz1 = pending[ra1] and hz2 = pending[ra2], combinationally, with no bypass of the current-cycle clear.
REQ-030 SHALL accept issue and writeback handshakes in the same cycle independently.

Reset
REQ-031 SHALL, while rst_n=0, force pending=0, rf_we=0, rf_wa=0, rf_wd=0, and last_grant=LSU, so EXU wins the first tie.
REQ-032 SHALL discard any accepted-but-unwritten writeback when reset is asserted mid-operation; no rf_we pulse after reset release until a new accept.
REQ-033 SHALL, while rst_n=0, drive exu_ready, lsu_ready and issue_ready low.

Verification
REQ-034 SHALL cover: reset, then issue rd=5 -> pending[5]=1 next cycle; EXU wb rd=5 data=0xDEADBEEF -> rf_we=1 rf_wa=5 rf_wd=0xDEADBEEF one cycle later, pending[5]=0.
REQ-035 SHALL cover: both valid for 4 cycles, EXU rd=1 and LSU rd=2 each dropping after grant then re-raising -> grants alternate EXU, LSU, EXU, LSU.
REQ-036 SHALL cover: pending[7]=1, issue rd=7 -> issue_ready=0; same cycle LSU wb rd=7 -> issue_ready=1 the next cycle.
REQ-037 SHALL cover: issue rd=3 and wb rd=3 accepted in the same cycle -> pending[3]=1 and rf_we=1 to x3 next cycle.
REQ-038 SHALL cover: wb rd=0 data=0x1234 -> handshake accepted, rf_we=0, pending[0]=0; ra1=0 -> hz1=0.
REQ-039 SHALL cover: rst_n pulsed low in the cycle after an accept -> no rf_we pulse, pending all zero.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for one register-file write port: round-robin EXU/LSU grant,
// registered write port, and a pending-writeback scoreboard for issue stalls and RAW hazards.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [ADDR_WIDTH-1:0]    issue_rd,
    output logic                     issue_ready,
    input  logic                     exu_valid,
    input  logic [ADDR_WIDTH-1:0]    exu_rd,
    input  logic [DATA_WIDTH-1:0]    exu_data,
    output logic                     exu_ready,
    input  logic                     lsu_valid,
    input  logic [ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     lsu_ready,
    output logic                     rf_we,
    output logic [ADDR_WIDTH-1:0]    rf_wa,
    output logic [DATA_WIDTH-1:0]    rf_wd,
    input  logic [ADDR_WIDTH-1:0]    ra1,
    input  logic [ADDR_WIDTH-1:0]    ra2,
    output logic                     hz1,
    output logic                     hz2,
    output logic [2**ADDR_WIDTH-1:0] pending
);

    typedef enum logic {
        GNT_EXU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    grant_e                  last_grant;
    logic                    exu_acc;
    logic                    lsu_acc;
    logic                    wb_acc;
    logic                    issue_acc;
    logic [ADDR_WIDTH-1:0]   wb_rd;
    logic [DATA_WIDTH-1:0]   wb_data;
    logic [2**ADDR_WIDTH-1:0] pending_next;

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        exu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (rst_n) begin
            if (exu_valid && (!lsu_valid || last_grant == GNT_LSU)) begin
                exu_ready = 1'b1;
            end else if (lsu_valid) begin
                lsu_ready = 1'b1;
            end
        end
    end

    // pending[0] is never set, so x0 never stalls issue
    assign issue_ready = rst_n && !pending[issue_rd];

    assign exu_acc   = exu_valid && exu_ready;
    assign lsu_acc   = lsu_valid && lsu_ready;
    assign wb_acc    = exu_acc || lsu_acc;
    assign issue_acc = issue_valid && issue_ready && (issue_rd != '0);
    assign wb_rd     = lsu_acc ? lsu_rd : exu_rd;
    assign wb_data   = lsu_acc ? lsu_data : exu_data;

    // Set is applied after clear so a new producer keeps the register pending.
    always_comb begin
        pending_next = pending;
        if (wb_acc) begin
            pending_next[wb_rd] = 1'b0;
        end
        if (issue_acc) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            last_grant <= GNT_LSU;
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
        end else begin
            pending <= pending_next;
            rf_we   <= wb_acc && (wb_rd != '0);
            if (exu_acc) begin
                last_grant <= GNT_EXU;
            end else if (lsu_acc) begin
                last_grant <= GNT_LSU;
            end
            if (wb_acc) begin
                rf_wa <= wb_rd;
                rf_wd <= wb_data;
            end
        end
    end

    assign hz1 = pending[ra1];
    assign hz2 = pending[ra2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a per-cycle reference model predicts grants,
// stalls and hazards; accepted writebacks are queued and checked by an independent write-port monitor.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid, exu_valid, lsu_valid;
    logic [AW-1:0] issue_rd, exu_rd, lsu_rd, ra1, ra2;
    logic [DW-1:0] exu_data, lsu_data;
    logic          issue_ready, exu_ready, lsu_ready, rf_we, hz1, hz2;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [NR-1:0] pending;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .ra1(ra1), .ra2(ra2), .hz1(hz1), .hz2(hz2), .pending(pending)
    );

    typedef struct {
        int            due;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_t;

    wb_t           sbq[$];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    bit            m_pend[NR];
    bit            m_last_lsu;
    logic          s_exu_ready, s_lsu_ready, s_issue_ready;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Write-port monitor: each accepted non-x0 writeback must appear exactly one cycle later.
    always @(negedge clk) begin
        bit due_now;
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            check("wb_missing", 64'(sbq[0].rd), 64'hFFFF);
            void'(sbq.pop_front());
        end
        due_now = (sbq.size() > 0) && (sbq[0].due == cyc);
        check("rf_we", 64'(rf_we), 64'(due_now));
        if (rf_we && due_now) begin
            check("rf_wa", 64'(rf_wa), 64'(sbq[0].rd));
            check("rf_wd", 64'(rf_wd), 64'(sbq[0].data));
            void'(sbq.pop_front());
        end
    end

    // One cycle: predict and compare combinational outputs, then advance the model.
    task automatic drive_cycle();
        bit            e_exu, e_lsu, e_iss;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        @(negedge clk);
        e_iss = rst_n && (issue_rd == 0 || !m_pend[issue_rd]);
        if (!rst_n) begin
            e_exu = 1'b0;
            e_lsu = 1'b0;
        end else if (exu_valid && lsu_valid) begin
            e_exu = m_last_lsu;
            e_lsu = !m_last_lsu;
        end else begin
            e_exu = exu_valid;
            e_lsu = lsu_valid;
        end
        check("exu_ready", 64'(exu_ready), 64'(e_exu));
        check("lsu_ready", 64'(lsu_ready), 64'(e_lsu));
        check("issue_ready", 64'(issue_ready), 64'(e_iss));
        check("hz1", 64'(hz1), 64'(m_pend[ra1]));
        check("hz2", 64'(hz2), 64'(m_pend[ra2]));
        check("pending", 64'(pending), 64'(model_vec()));
        s_exu_ready   = exu_ready;
        s_lsu_ready   = lsu_ready;
        s_issue_ready = issue_ready;
        if (rst_n) begin
            if (e_exu || e_lsu) begin
                rd   = e_lsu ? lsu_rd : exu_rd;
                data = e_lsu ? lsu_data : exu_data;
                if (rd != 0) sbq.push_back('{cyc + 1, rd, data});
                m_pend[rd] = 1'b0;
                m_last_lsu = e_lsu;
            end
            if (issue_valid && e_iss && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; exu_valid = 0; lsu_valid = 0;
        issue_rd = 0; exu_rd = 0; lsu_rd = 0; ra1 = 0; ra2 = 0;
        exu_data = 0; lsu_data = 0;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        sbq.delete();
        for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
        m_last_lsu = 1'b1;
        repeat (n) drive_cycle();
        check("rst_rf_wa", 64'(rf_wa), 64'h0);
        check("rst_rf_wd", 64'(rf_wd), 64'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] grants;
        idle();
        #1;
        issue_valid = 1; issue_rd = 4; exu_valid = 1; lsu_valid = 1;
        apply_reset(3);
        idle();
        drive_cycle();

        // issue x5, then EXU writes 0xDEADBEEF to x5
        issue_valid = 1; issue_rd = 5; ra1 = 5;
        drive_cycle();
        issue_valid = 0;
        drive_cycle();
        check("p5_set", 64'(pending[5]), 64'h1);
        exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
        drive_cycle();
        idle();
        drive_cycle();
        check("p5_clear", 64'(pending[5]), 64'h0);

        // tie alternation from reset: EXU, LSU, EXU, LSU
        apply_reset(1);
        exu_valid = 1; exu_rd = 1; lsu_valid = 1; lsu_rd = 2;
        for (int i = 0; i < 4; i++) begin
            drive_cycle();
            grants[i] = s_exu_ready;
            if (s_exu_ready) exu_data = $urandom; else lsu_data = $urandom;
        end
        check("tie_alternate", 64'(grants), 64'h5);
        idle();

        // WAW stall on x7 released by LSU writeback in the same cycle
        issue_valid = 1; issue_rd = 7;
        drive_cycle();
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h0000_7777;
        drive_cycle();
        check("waw_stall", 64'(s_issue_ready), 64'h0);
        lsu_valid = 0;
        drive_cycle();
        check("waw_release", 64'(s_issue_ready), 64'h1);
        idle();
        drive_cycle();

        // issue x3 and writeback x3 together: set wins, write still happens
        issue_valid = 1; issue_rd = 3; exu_valid = 1; exu_rd = 3; exu_data = 32'h3333_0003;
        drive_cycle();
        idle(); ra2 = 3;
        drive_cycle();
        check("p3_set_wins", 64'(pending[3]), 64'h1);

        // writeback to x0 is accepted but never written
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234; ra1 = 0;
        drive_cycle();
        check("x0_accept", 64'(s_lsu_ready), 64'h1);
        idle();
        drive_cycle();
        check("x0_hz1", 64'(hz1), 64'h0);

        // reset right after an accept discards the write
        issue_valid = 1; issue_rd = 9;
        drive_cycle();
        issue_valid = 0; exu_valid = 1; exu_rd = 9; exu_data = 32'h9999_0009;
        drive_cycle();
        idle();
        apply_reset(1);
        repeat (3) drive_cycle();
        check("rst_pending", 64'(pending), 64'h0);

        // randomized traffic honoring the hold-while-stalled rule
        for (int n = 0; n < 600; n++) begin
            if (!(exu_valid && !s_exu_ready)) begin
                exu_valid = 1'($urandom_range(0, 1)); exu_rd = 5'($urandom_range(0, 7)); exu_data = $urandom;
            end
            if (!(lsu_valid && !s_lsu_ready)) begin
                lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = 5'($urandom_range(0, 7));
            ra1 = 5'($urandom_range(0, 7));
            ra2 = 5'($urandom_range(0, 7));
            drive_cycle();
        end
        idle();
        repeat (3) drive_cycle();
        check("sbq_drained", 64'(sbq.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
